// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined LEGv8 immediate generator.
package imm_pkg;

    localparam int unsigned IMM_W      = 26;
    localparam int unsigned CTRL_W     = 3;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned HALF_W     = 16;

    // Extension modes carried on Ctrl; 101 and 110 are unassigned.
    typedef enum logic [CTRL_W-1:0] {
        CTRL_D    = 3'b000,
        CTRL_I    = 3'b001,
        CTRL_B    = 3'b010,
        CTRL_CB   = 3'b011,
        CTRL_MOVK = 3'b100,
        CTRL_MOVZ = 3'b111
    } ctrl_e;

    // Field positions inside the 26-bit instruction slice.
    localparam int unsigned D_LSB   = 12;
    localparam int unsigned D_MSB   = 20;
    localparam int unsigned I_LSB   = 10;
    localparam int unsigned I_MSB   = 21;
    localparam int unsigned CB_LSB  = 5;
    localparam int unsigned CB_MSB  = 23;
    localparam int unsigned MOV_LSB = 5;
    localparam int unsigned MOV_MSB = 20;
    localparam int unsigned HW_LSB  = 21;
    localparam int unsigned HW_MSB  = 22;

    localparam int unsigned D_W  = D_MSB - D_LSB + 1;
    localparam int unsigned I_W  = I_MSB - I_LSB + 1;
    localparam int unsigned CB_W = CB_MSB - CB_LSB + 1;

    // One pipeline entry; data is sized for the widest build and truncated at the port.
    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic                  err;
    } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: Imm26/Ctrl/OldVal -> {data, err}.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter bit          SHIFT_BR = 1'b0
) (
    input  logic [IMM_W-1:0]  imm26,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [DATA_W-1:0] old_val,
    output entry_t            entry_c
);

    logic [MAX_DATA_W-1:0] wide;
    logic [MAX_DATA_W-1:0] old_w;
    logic [HALF_W-1:0]     field;
    logic [1:0]            hw;
    logic [5:0]            sh;
    logic                  hw_bad;
    logic                  err;

    // Mode decode done at full width, then truncated to DATA_W.
    always_comb begin
        wide   = '0;
        err    = 1'b0;
        hw     = imm26[HW_MSB:HW_LSB];
        sh     = {hw, 4'b0000};
        field  = imm26[MOV_MSB:MOV_LSB];
        hw_bad = (32'(sh) >= DATA_W);
        old_w  = MAX_DATA_W'(old_val);

        case (ctrl)
            CTRL_D:  wide = {{(MAX_DATA_W-D_W){imm26[D_MSB]}}, imm26[D_MSB:D_LSB]};
            CTRL_I:  wide = {{(MAX_DATA_W-I_W){1'b0}}, imm26[I_MSB:I_LSB]};
            CTRL_B: begin
                wide = {{(MAX_DATA_W-IMM_W){imm26[IMM_W-1]}}, imm26};
                if (SHIFT_BR) wide = wide << 2;
            end
            CTRL_CB: begin
                wide = {{(MAX_DATA_W-CB_W){imm26[CB_MSB]}}, imm26[CB_MSB:CB_LSB]};
                if (SHIFT_BR) wide = wide << 2;
            end
            CTRL_MOVZ: begin
                if (hw_bad) err = 1'b1;
                else        wide = MAX_DATA_W'(field) << sh;
            end
            CTRL_MOVK: begin
                if (hw_bad) err = 1'b1;
                else        wide = (old_w & ~(MAX_DATA_W'(16'hFFFF) << sh))
                                 | (MAX_DATA_W'(field) << sh);
            end
            default: err = 1'b1;
        endcase

        entry_c.data = MAX_DATA_W'(wide[DATA_W-1:0]);
        entry_c.err  = err;
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator with valid/ready handshake, 2-entry skid and error counter.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter bit          SHIFT_BR  = 1'b0,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_W-1:0]     Imm26,
    input  logic [CTRL_W-1:0]    Ctrl,
    input  logic [DATA_W-1:0]    OldVal,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    BusImm,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("imm_extend_pipe: DATA_W must be 32 or 64");
    end

    entry_t                dec_c;
    entry_t                out_q, out_d;
    entry_t                skid_q, skid_d;
    logic                  out_vld_q, out_vld_d;
    logic                  skid_full_q, skid_full_d;
    logic [ERR_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  accept_c;
    logic                  xfer_c;

    imm_decode #(
        .DATA_W   (DATA_W),
        .SHIFT_BR (SHIFT_BR)
    ) u_decode (
        .imm26   (Imm26),
        .ctrl    (Ctrl),
        .old_val (OldVal),
        .entry_c (dec_c)
    );

    // Ready depends only on held state, never on out_ready.
    assign in_ready = ~skid_full_q & ~Reset;
    assign accept_c = in_valid & in_ready;
    assign xfer_c   = out_vld_q & out_ready;

    // Next-state for output register, skid register and error counter.
    always_comb begin
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        cnt_d       = cnt_q;

        if (skid_full_q) begin
            if (xfer_c) begin
                out_d       = skid_q;
                out_vld_d   = 1'b1;
                skid_full_d = 1'b0;
            end
        end else if (out_vld_q && !out_ready) begin
            if (accept_c) begin
                skid_d      = dec_c;
                skid_full_d = 1'b1;
            end
        end else begin
            if (accept_c) begin
                out_d     = dec_c;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        if (accept_c && dec_c.err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_vld_q;
    assign BusImm    = out_q.data[DATA_W-1:0];
    assign out_err   = out_q.err;
    assign err_count = cnt_q;

endmodule
